div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_div_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// div_sequencer: 32-bit radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Revision: 1.0
// ============================================================================

module cla (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o
);
  logic [31:0] p;
  logic [31:0] g;
  logic [31:0] c;
  logic [7:0]  gc;

  assign p     = a_i ^ b_i;
  assign g     = a_i & b_i;
  assign gc[0] = cin_i;

  // Eight 4-bit lookahead groups; group generate/propagate ripple between groups.
  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    localparam int B = 4 * gi;
    assign c[B]   = gc[gi];
    assign c[B+1] = g[B] | (p[B] & gc[gi]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[gi]);
    if (gi < 7) begin : g_carry
      logic grp_g;
      logic grp_p;
      assign grp_g = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                   | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign grp_p = &p[B+3:B];
      assign gc[gi+1] = grp_g | (grp_p & gc[gi]);
    end
  end

  assign sum_o = p ^ c;
endmodule

module div_sequencer #(
  parameter bit DIV0_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvsr_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        div0_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        is_div0;
  logic        is_ovf;

  always_comb begin
    a_neg   = is_signed & dividend[31];
    b_neg   = is_signed & divisor[31];
    a_mag   = a_neg ? (~dividend + 32'd1) : dividend;
    b_mag   = b_neg ? (~divisor + 32'd1) : divisor;
    is_div0 = (divisor == 32'd0);
    is_ovf  = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  end

  logic [32:0] shift_d;
  logic [31:0] dvsr_inv;
  logic [31:0] diff;
  logic        carry31;
  logic        cout;
  logic        step_ok;
  logic [31:0] rem_d;
  logic [31:0] quo_d;

  assign shift_d  = {rem_q, quo_q[31]};
  assign dvsr_inv = ~dvsr_q;

  cla u_cla (
    .a_i   (shift_d[31:0]),
    .b_i   (dvsr_inv),
    .cin_i (1'b1),
    .sum_o (diff)
  );

  // Carry into bit 31 is recovered from the sum, giving the adder's carry-out.
  assign carry31 = diff[31] ^ shift_d[31] ^ dvsr_inv[31];
  assign cout    = (shift_d[31] & dvsr_inv[31]) | (shift_d[31] & carry31)
                 | (dvsr_inv[31] & carry31);
  assign step_ok = shift_d[32] | cout;
  assign rem_d   = step_ok ? diff : shift_d[31:0];
  assign quo_d   = {quo_q[30:0], step_ok};

  logic [31:0] fix_q;
  logic [31:0] fix_r;

  // A slow-path divide-by-zero must still report all-ones regardless of sign.
  assign fix_q = div0_q ? 32'hFFFF_FFFF : (q_neg_q ? (~quo_q + 32'd1) : quo_q);
  assign fix_r = r_neg_q ? (~rem_q + 32'd1) : rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      dvsr_q      <= 32'd0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            q_neg_q    <= a_neg ^ b_neg;
            r_neg_q    <= a_neg;
            div0_q     <= is_div0;
            dvsr_q     <= b_mag;
            quo_q      <= a_mag;
            rem_q      <= 32'd0;
            cnt_q      <= 6'd0;
            in_ready_q <= 1'b0;
            if (DIV0_FAST && is_div0) begin
              quotient_q  <= 32'hFFFF_FFFF;
              remainder_q <= dividend;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (DIV0_FAST && is_ovf) begin
              quotient_q  <= 32'h8000_0000;
              remainder_q <= 32'd0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quotient_q  <= fix_q;
          remainder_q <= fix_r;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// tb_div_sequencer: scoreboard-based self-checking bench for div_sequencer,
// covering both the fast and the full-iteration special-case paths.
module tb_div_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  logic        in_valid_s = 1'b0;
  logic        out_ready_s = 1'b0;
  logic        in_ready_s;
  logic        out_valid_s;
  logic [31:0] quotient_s;
  logic [31:0] remainder_s;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  div_sequencer #(.DIV0_FAST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder)
  );

  div_sequencer #(.DIV0_FAST(1'b0)) dut_slow (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
    .out_valid(out_valid_s), .out_ready(out_ready_s),
    .quotient(quotient_s), .remainder(remainder_s)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    exp_t e;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else if (sgn) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Scoreboard: every handshake on the fast-path DUT pops one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: got q=%h r=%h, no result expected", quotient, remainder);
      end else begin
        mon_e = sb.pop_front();
        if (quotient !== mon_e.q || remainder !== mon_e.r) begin
          errors++;
          $display("FAIL sb_result: got q=%h r=%h, expected q=%h r=%h",
                   quotient, remainder, mon_e.q, mon_e.r);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    for (int i = 0; i < 100 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(a, b, sgn));
  endtask

  task automatic wait_valid(output int k);
    k = 1;
    while (!out_valid && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (!out_valid) k = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int k;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b q=%h r=%h, expected 1 0 0 0",
               in_ready, out_valid, quotient, remainder);
    end
    dividend  = 32'd100;
    divisor   = 32'd7;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(32'd100, 32'd7, 1'b0));
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL first_accept: in_ready=%b after first edge, expected 0", in_ready);
    end
    wait_valid(k);
    checks++;
    if (k !== 34) begin
      errors++;
      $display("FAIL reset_lat: out_valid at T+%0d, expected T+34", k);
    end
    consume();
  endtask

  task automatic test_unsigned();
    logic [31:0] va[4] = '{32'd100, 32'hFFFF_FFFF, 32'd0, 32'd5};
    logic [31:0] vb[4] = '{32'd7, 32'd1, 32'd5, 32'd9};
    int k;
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], 1'b0);
      wait_valid(k);
      checks++;
      if (k !== 34) begin
        errors++;
        $display("FAIL unsigned_lat[%0d]: out_valid at T+%0d, expected T+34", i, k);
      end
      consume();
    end
  endtask

  task automatic test_signed();
    logic [31:0] va[4] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FF9C, 32'h8000_0000};
    logic [31:0] vb[4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd1};
    int k;
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], 1'b1);
      wait_valid(k);
      checks++;
      if (k !== 34) begin
        errors++;
        $display("FAIL signed_lat[%0d]: out_valid at T+%0d, expected T+34", i, k);
      end
      consume();
    end
  endtask

  task automatic test_fast_path();
    logic [31:0] va[4] = '{32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFB, 32'h8000_0000};
    logic [31:0] vb[4] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
    logic        vs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int k;
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], vs[i]);
      wait_valid(k);
      checks++;
      if (k !== exp_lat(va[i], vb[i], vs[i])) begin
        errors++;
        $display("FAIL fast_lat[%0d]: out_valid at T+%0d, expected T+%0d",
                 i, k, exp_lat(va[i], vb[i], vs[i]));
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int k;
    exp_t e;
    e = model(32'd1000, 32'd3, 1'b0);
    send(32'd1000, 32'd3, 1'b0);
    wait_valid(k);
    checks++;
    if (k !== 34) begin
      errors++;
      $display("FAIL bp_lat: out_valid at T+%0d, expected T+34", k);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = $urandom;
      divisor  = $urandom;
      checks++;
      if (quotient !== e.q || remainder !== e.r || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: q=%h r=%h in_ready=%b out_valid=%b, expected q=%h r=%h 0 1",
                 i, quotient, remainder, in_ready, out_valid, e.q, e.r);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    send(32'd50, 32'd6, 1'b0);
    wait_valid(k);
    dividend  = 32'd77;
    divisor   = 32'd5;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_accept: in_ready=%b out_valid=%b after consume, expected 1 0",
               in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(32'd77, 32'd5, 1'b0));
    wait_valid(k);
    checks++;
    if (k !== 34) begin
      errors++;
      $display("FAIL b2b_lat: out_valid at T+%0d, expected T+34", k);
    end
    consume();
  endtask

  task automatic test_reset_mid_calc();
    int k;
    send(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if (out_valid !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b q=%h r=%h in_ready=%b, expected 0 0 0 1",
               out_valid, quotient, remainder, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(32'd100, 32'd7, 1'b0);
    wait_valid(k);
    checks++;
    if (k !== 34) begin
      errors++;
      $display("FAIL mid_reset_lat: out_valid at T+%0d, expected T+34", k);
    end
    consume();
  endtask

  task automatic test_random();
    int k;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 5) b = 32'd0;
      s = 1'($urandom_range(0, 1));
      send(a, b, s);
      wait_valid(k);
      checks++;
      if (k !== exp_lat(a, b, s)) begin
        errors++;
        $display("FAIL rand_lat[%0d]: out_valid at T+%0d, expected T+%0d", i, k, exp_lat(a, b, s));
      end
      consume();
    end
  endtask

  task automatic test_slow_path();
    logic [31:0] va[3] = '{32'h1234_5678, 32'hFFFF_FFFB, 32'h8000_0000};
    logic [31:0] vb[3] = '{32'd0, 32'd0, 32'hFFFF_FFFF};
    logic        vs[3] = '{1'b0, 1'b1, 1'b1};
    exp_t e;
    int k;
    for (int i = 0; i < 3; i++) begin
      e = model(va[i], vb[i], vs[i]);
      for (int w = 0; w < 100 && !in_ready_s; w++) begin
        @(posedge clk); #1;
      end
      dividend   = va[i];
      divisor    = vb[i];
      is_signed  = vs[i];
      in_valid_s = 1'b1;
      @(posedge clk); #1;
      in_valid_s = 1'b0;
      k = 1;
      while (!out_valid_s && k < 60) begin
        @(posedge clk); #1;
        k++;
      end
      checks++;
      if (k !== 34 || quotient_s !== e.q || remainder_s !== e.r) begin
        errors++;
        $display("FAIL slow_path[%0d]: T+%0d q=%h r=%h, expected T+34 q=%h r=%h",
                 i, k, quotient_s, remainder_s, e.q, e.r);
      end
      out_ready_s = 1'b1;
      @(posedge clk); #1;
      out_ready_s = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_fast_path();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    test_slow_path();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d results never produced", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
